// File: rtl/modexp_seq.sv
// Sequential modular exponentiation: o_final_message = i_message ^ i_key mod i_modulo.
// Left-to-right square-and-multiply over an interleaved shift-add modular multiplier.
module modexp_seq #(
    parameter int W  = 64,
    parameter int EW = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [W-1:0]  i_message,
    input  logic [W-1:0]  i_modulo,
    input  logic [EW-1:0] i_key,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [W-1:0]  o_final_message
);

    // state  | meaning
    // S_IDLE | waiting for start, outputs cleared
    // S_BIT  | examine key[idx], choose square / multiply / skip
    // S_SQR  | R = R*R mod M (load cycle + W iterations)
    // S_MUL  | R = R*message mod M (load cycle + W iterations)
    // S_DONE | result (or error) held until next start
    localparam int IW = (EW > 1) ? $clog2(EW) : 1;
    localparam int JW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {S_IDLE, S_BIT, S_SQR, S_MUL, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [W-1:0]  r_msg;
    logic [W-1:0]  r_mod;
    logic [EW-1:0] r_key;
    logic [W-1:0]  r_res;
    logic [W+1:0]  r_p;
    logic [IW-1:0] r_idx;
    logic [JW-1:0] r_j;
    logic          r_seen;
    logic          r_load;
    logic          r_err;

    logic          w_valid;
    logic          w_key_bit;
    logic          w_last;
    logic          w_j_zero;
    logic          w_mul_end;
    logic          w_a_bit;
    logic [W-1:0]  w_b;
    logic [W+1:0]  w_mod_ext;
    logic [W+1:0]  w_sum;
    logic [W+1:0]  w_red1;
    logic [W+1:0]  w_red2;

    assign w_valid   = (i_modulo >= W'(2)) && (i_message < i_modulo);
    assign w_key_bit = r_key[r_idx];
    assign w_last    = (r_idx == '0);
    assign w_j_zero  = (r_j == '0);
    assign w_mul_end = ((r_state == S_SQR) || (r_state == S_MUL)) && !r_load && w_j_zero;

    // P < M holds between iterations, so 2P + B < 3M and two conditional subtracts suffice
    assign w_a_bit   = r_res[r_j];
    assign w_b       = (r_state == S_SQR) ? r_res : r_msg;
    assign w_mod_ext = {2'b00, r_mod};
    assign w_sum     = (r_p << 1) + {2'b00, (w_a_bit ? w_b : '0)};
    assign w_red1    = (w_sum >= w_mod_ext) ? (w_sum - w_mod_ext) : w_sum;
    assign w_red2    = (w_red1 >= w_mod_ext) ? (w_red1 - w_mod_ext) : w_red1;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) w_state_nxt = w_valid ? S_BIT : S_DONE;
            end
            S_BIT: begin
                if (r_seen)         w_state_nxt = S_SQR;
                else if (w_key_bit) w_state_nxt = S_MUL;
                else if (w_last)    w_state_nxt = S_DONE;
            end
            S_SQR: begin
                if (w_mul_end) begin
                    if (w_key_bit)   w_state_nxt = S_MUL;
                    else if (w_last) w_state_nxt = S_DONE;
                    else             w_state_nxt = S_BIT;
                end
            end
            S_MUL: begin
                if (w_mul_end) w_state_nxt = w_last ? S_DONE : S_BIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_msg  <= '0;
            r_mod  <= '0;
            r_key  <= '0;
            r_res  <= '0;
            r_p    <= '0;
            r_idx  <= '0;
            r_j    <= '0;
            r_seen <= 1'b0;
            r_load <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_msg  <= i_message;
                        r_mod  <= i_modulo;
                        r_key  <= i_key;
                        r_res  <= w_valid ? W'(1) : '0;
                        r_err  <= !w_valid;
                        r_idx  <= IW'(EW - 1);
                        r_seen <= 1'b0;
                        r_load <= 1'b0;
                    end
                end
                S_BIT: begin
                    r_seen <= r_seen | w_key_bit;
                    if (r_seen || w_key_bit) r_load <= 1'b1;
                    else if (!w_last)        r_idx  <= r_idx - IW'(1);
                end
                S_SQR, S_MUL: begin
                    if (r_load) begin
                        r_p    <= '0;
                        r_j    <= JW'(W - 1);
                        r_load <= 1'b0;
                    end else begin
                        r_p <= w_red2;
                        r_j <= r_j - JW'(1);
                        if (w_j_zero) begin
                            r_res <= w_red2[W-1:0];
                            // a square followed by a multiply keeps idx for the MUL pass
                            if ((r_state == S_SQR) && w_key_bit) r_load <= 1'b1;
                            else if (!w_last)                    r_idx  <= r_idx - IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy          = (r_state == S_BIT) || (r_state == S_SQR) || (r_state == S_MUL);
    assign o_done          = (r_state == S_DONE);
    assign o_err           = r_err;
    assign o_final_message = o_done ? r_res : '0;

endmodule

// File: tb/tb_modexp_seq.sv
// Directed bench for modexp_seq (W=EW=16): results, exact latency, errors, reset and start handling.
module tb_modexp_seq;
    localparam int W  = 16;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  message;
    logic [W-1:0]  modulo;
    logic [EW-1:0] key;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  final_message;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    modexp_seq #(.W(W), .EW(EW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_message       (message),
        .i_modulo        (modulo),
        .i_key           (key),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err),
        .o_final_message (final_message)
    );

    // Drives one job and reports what was observed; cyc counts from the accept cycle (1 = first sample after the accept edge)
    task automatic run_job(input logic [W-1:0] m, input logic [W-1:0] md, input logic [EW-1:0] k,
                           input int poke_at, output logic [W-1:0] res, output logic e,
                           output int cyc, output int busyc, output logic done1);
        @(negedge clk);
        message = m; modulo = md; key = k; start = 1'b1;
        cyc = 0; busyc = 0; done1 = 1'b1;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0; done1 = done;
                message = '0; modulo = '0; key = '0;
            end
            if (cyc == poke_at) begin
                start = 1'b1; message = 16'd3; modulo = 16'd7; key = 16'd5;
            end
            if (cyc == poke_at + 1) start = 1'b0;
            if (busy) busyc++;
        end while (!done && cyc < 2000);
        res = final_message;
        e   = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; message = 16'd4; modulo = 16'd497; key = 16'd13;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
        tests_run++; if (final_message !== 16'd0) begin tests_failed++; $display("FAIL reset_result: got %0d expected 0", final_message); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] res; logic e, d1; int cyc, bc;
        run_job(16'd4, 16'd497, 16'd13, -1, res, e, cyc, bc, d1);
        tests_run++; if (res !== 16'd445) begin tests_failed++; $display("FAIL basic_result: got %0d expected 445", res); end
        tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got %b expected 0", e); end
        tests_run++; if (cyc !== 119) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 119", cyc); end
        tests_run++; if (bc !== 118) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d expected 118", bc); end
    endtask

    task automatic test_key_zero();
        logic [W-1:0] res; logic e, d1; int cyc, bc;
        run_job(16'd5, 16'd497, 16'd0, -1, res, e, cyc, bc, d1);
        tests_run++; if (res !== 16'd1) begin tests_failed++; $display("FAIL keyzero_result: got %0d expected 1", res); end
        tests_run++; if (cyc !== 17) begin tests_failed++; $display("FAIL keyzero_latency: got %0d expected 17", cyc); end
        tests_run++; if (bc !== 16) begin tests_failed++; $display("FAIL keyzero_busy_cycles: got %0d expected 16", bc); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res; logic e, d1; int cyc, bc;
        run_job(16'd65, 16'd3233, 16'd17, -1, res, e, cyc, bc, d1);
        tests_run++; if (res !== 16'd2790) begin tests_failed++; $display("FAIL rsa_enc_result: got %0d expected 2790", res); end
        tests_run++; if (cyc !== 119) begin tests_failed++; $display("FAIL rsa_enc_latency: got %0d expected 119", cyc); end
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL rsa_done_held: got %b expected 1", done); end
        tests_run++; if (final_message !== 16'd2790) begin tests_failed++; $display("FAIL rsa_result_held: got %0d expected 2790", final_message); end
        run_job(16'd2790, 16'd3233, 16'd2753, -1, res, e, cyc, bc, d1);
        tests_run++; if (d1 !== 1'b0) begin tests_failed++; $display("FAIL rsa_done_drop: got %b expected 0", d1); end
        tests_run++; if (res !== 16'd65) begin tests_failed++; $display("FAIL rsa_dec_result: got %0d expected 65", res); end
        tests_run++; if (cyc !== 289) begin tests_failed++; $display("FAIL rsa_dec_latency: got %0d expected 289", cyc); end
    endtask

    task automatic test_invalid();
        logic [W-1:0] res; logic e, d1; int cyc, bc;
        run_job(16'd0, 16'd1, 16'd5, -1, res, e, cyc, bc, d1);
        tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL inv_mod_err: got %b expected 1", e); end
        tests_run++; if (res !== 16'd0) begin tests_failed++; $display("FAIL inv_mod_result: got %0d expected 0", res); end
        tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL inv_mod_latency: got %0d expected 1", cyc); end
        tests_run++; if (bc !== 0) begin tests_failed++; $display("FAIL inv_mod_busy: got %0d expected 0", bc); end
        run_job(16'd500, 16'd497, 16'd3, -1, res, e, cyc, bc, d1);
        tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL inv_msg_err: got %b expected 1", e); end
        tests_run++; if (res !== 16'd0) begin tests_failed++; $display("FAIL inv_msg_result: got %0d expected 0", res); end
        tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL inv_msg_latency: got %0d expected 1", cyc); end
        run_job(16'd2, 16'd497, 16'd3, -1, res, e, cyc, bc, d1);
        tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", e); end
        tests_run++; if (res !== 16'd8) begin tests_failed++; $display("FAIL after_err_result: got %0d expected 8", res); end
        tests_run++; if (cyc !== 68) begin tests_failed++; $display("FAIL after_err_latency: got %0d expected 68", cyc); end
    endtask

    task automatic test_max_width();
        logic [W-1:0] res; logic e, d1; int cyc, bc;
        run_job(16'd65520, 16'd65521, 16'd65535, -1, res, e, cyc, bc, d1);
        tests_run++; if (res !== 16'd65520) begin tests_failed++; $display("FAIL maxw_result: got %0d expected 65520", res); end
        tests_run++; if (cyc !== 544) begin tests_failed++; $display("FAIL maxw_latency: got %0d expected 544", cyc); end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] res; logic e, d1; int cyc, bc;
        run_job(16'd4, 16'd497, 16'd13, 30, res, e, cyc, bc, d1);
        tests_run++; if (res !== 16'd445) begin tests_failed++; $display("FAIL ignore_start_result: got %0d expected 445", res); end
        tests_run++; if (cyc !== 119) begin tests_failed++; $display("FAIL ignore_start_latency: got %0d expected 119", cyc); end
    endtask

    task automatic test_rst_mid_job();
        logic [W-1:0] res; logic e, d1; int cyc, bc;
        @(negedge clk);
        message = 16'd4; modulo = 16'd497; key = 16'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // 13 = 1101b: first square of the job runs around cycles 32..48 after accept
        repeat (39) @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        rst = 1'b1; start = 1'b1; message = 16'd3; modulo = 16'd7; key = 16'd5;
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        tests_run++; if (final_message !== 16'd0) begin tests_failed++; $display("FAIL rst_mid_result: got %0d expected 0", final_message); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL rst_start_ignored: got busy=%b done=%b expected 0 0", busy, done); end
        run_job(16'd4, 16'd497, 16'd13, -1, res, e, cyc, bc, d1);
        tests_run++; if (res !== 16'd445) begin tests_failed++; $display("FAIL post_rst_result: got %0d expected 445", res); end
        tests_run++; if (cyc !== 119) begin tests_failed++; $display("FAIL post_rst_latency: got %0d expected 119", cyc); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; message = '0; modulo = '0; key = '0;
        test_reset();
        test_basic();
        test_key_zero();
        test_back_to_back();
        test_invalid();
        test_max_width();
        test_ignore_start();
        test_rst_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/modexp_seq.md
# modexp_seq

Parametrised sequential modular-exponentiation engine: computes final_message = message^key mod modulo. Uses left-to-right square-and-multiply over an interleaved shift-add modular multiplier, so no wide combinational multiplier or divider is needed. Adds a start/busy/done handshake, a separate exponent width, input checking with an error flag, and a cycle-exact latency. Serves as the RSA encrypt/decrypt core behind the key/message registers of the RSA datapath.

## Interface
- W, default 64: width of message, modulo and final_message (bits).
- EW, default 64: width of key (exponent, bits).
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- message  input  W  base; must be < modulo.
- modulo  input  W  modulus; must be >= 2.
- key  input  EW  exponent.
- busy  output  1  high while a job is in progress.
- done  output  1  high while a finished result is held.
- err  output  1  high with done when inputs were invalid.
- final_message  output  W  result; valid while done=1.

## Operation
- States: IDLE, BIT, SQR, MUL, DONE.
- Start accept:
  - start=1 in IDLE or DONE latches message, modulo and key.
  - Same edge: clears done/err, sets R=1, idx=EW-1, seen=0.
  - If modulo<2 or message>=modulo: go to DONE with err=1, final_message=0.
  - Otherwise: go to BIT with busy=1.
- start in BIT/SQR/MUL is ignored; the in-flight job is unaffected.
- BIT (1 cycle per key bit, idx from EW-1 down to 0):
  - If seen=1: go to SQR (R=R*R mod M).
  - Else if key[idx]=1: go to MUL (R=R*message mod M).
  - Else: no multiply.
  - After the multiply(s), or immediately if none, decrement idx and return to BIT.
  - After SQR, go to MUL if key[idx]=1.
  - seen |= key[idx].
  - After idx=0 is processed, go to DONE.
- key=0: no multiplies; result = 1.
- mulmod(A,B) occupies SQR or MUL for W+1 cycles:
  - Load cycle: P=0, j=W-1.
  - W iteration cycles: P = 2P + (A[j] ? B : 0), then subtract M at most twice while P>=M.
  - P is W+2 bits wide; invariant P<M.
  - R is written on the last iteration cycle.
- DONE: busy=0, done=1, final_message=R, held stable until the next accepted start or rst.
- rst at any point, mid-job included, returns to IDLE:
  - busy=0, done=0, err=0, final_message=0.
  - Latched operands cleared.

## Timing
- Reset values: busy=0, done=0, err=0, final_message=0.
- Let L = bit length of key and N = (L-1) + popcount(key), with N=0 if key=0.
- Valid job: done rises EW + N*(W+1) + 1 cycles after the start-accept edge.
- busy is high for exactly EW + N*(W+1) cycles; busy falls on the same edge that done rises.
- Invalid job: done=1 and err=1 one cycle after accept; busy never rises.
- A start accepted in DONE drops done the next cycle. Back-to-back jobs have no idle gap.
- start coinciding with rst: rst wins, start is ignored.
- Inputs need only be stable on the accept edge.

## Test plan
- W=16, EW=16; message=4, modulo=497, key=13 -> final_message=445; done exactly 16+6*17+1=119 cycles after accept; err=0.
- W=16, EW=16; key=0, message=5, modulo=497 -> final_message=1; done after 17 cycles.
- W=16, EW=16; RSA n=3233: message=65, key=17 -> 2790; then start with message=2790, key=2753 -> 65. The second job is accepted while done=1.
- W=16, EW=16; modulo=1 -> err=1, final_message=0 after 1 cycle. Then message=500, modulo=497 -> err=1.
- W=16, EW=16; modulo=65521, message=65520, key=65535 -> final_message=65520, which checks the max-width reduction path.
- Pulse start mid-job -> ignored, original result unchanged. Then assert rst during SQR -> next cycle busy=0, done=0, final_message=0; a new job afterwards completes correctly.
